square_color_ctrl: RTL and testbench



---
 rtl/square_color_pkg.sv | 34 +++
 rtl/square_color_ctrl_if.sv | 27 ++
 rtl/square_color_ctrl_btn_sync_edge.sv | 29 ++
 rtl/square_color_ctrl.sv | 87 ++++++++
 tb/tb_square_color_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/square_color_pkg.sv
// Shared constants for the square colour panel controller.
//   - colour index constants (3-bit, 0..5)
//   - circle colour codes (2-bit, 3 is never driven)
//   - button slot numbering and controller state encoding
//   - idx_next: modulo increment with explicit wrap
package square_color_pkg;

  localparam logic [2:0] IDX_WHITE  = 3'd0;
  localparam logic [2:0] IDX_RED    = 3'd1;
  localparam logic [2:0] IDX_GREEN  = 3'd2;
  localparam logic [2:0] IDX_BLUE   = 3'd3;
  localparam logic [2:0] IDX_ORANGE = 3'd4;
  localparam logic [2:0] IDX_BLACK  = 3'd5;

  localparam logic [1:0] CIRC_BLACK  = 2'd0;
  localparam logic [1:0] CIRC_RED    = 2'd1;
  localparam logic [1:0] CIRC_ORANGE = 2'd2;

  // Slot order doubles as arbitration priority: lowest slot wins.
  localparam int NUM_BTNS = 3;
  localparam int BTN_U    = 0;
  localparam int BTN_C    = 1;
  localparam int BTN_D    = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_LOCKOUT = 1'b1
  } state_t;

  function automatic logic [2:0] idx_next(input logic [2:0] idx, input int unsigned n);
    return (idx == 3'(n - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/square_color_ctrl_if.sv
// Panel bundle between the button/renderer side and the controller.
//   btnU/btnC/btnD : raw asynchronous buttons (master -> slave)
//   up/ctr/dn_idx  : per-square colour indices (slave -> master)
//   circle_sel     : registered circle colour code
//   busy           : press lockout active
//   press_evt      : one-cycle pulse per accepted press
interface square_color_if;
  logic       btnU;
  logic       btnC;
  logic       btnD;
  logic [2:0] up_idx;
  logic [2:0] ctr_idx;
  logic [2:0] dn_idx;
  logic [1:0] circle_sel;
  logic       busy;
  logic       press_evt;

  modport master (
    output btnU, btnC, btnD,
    input  up_idx, ctr_idx, dn_idx, circle_sel, busy, press_evt
  );

  modport slave (
    input  btnU, btnC, btnD,
    output up_idx, ctr_idx, dn_idx, circle_sel, busy, press_evt
  );
endinterface

// File: rtl/square_color_ctrl_btn_sync_edge.sv
// Per-button 2-flop synchroniser plus rising-edge detect.
//   clk_khz_1  : clock
//   reset_task : synchronous active-high reset, clears all three flops
//   btn_raw    : asynchronous button
//   rise       : sync2 & ~prev (combinational from flops only)
// prev follows sync2 every cycle regardless of controller state, so a
// button held across a lockout window never re-triggers.
module btn_sync_edge (
  input  logic clk_khz_1,
  input  logic reset_task,
  input  logic btn_raw,
  output logic rise
);
  logic sync1, sync2, prev;

  always_ff @(posedge clk_khz_1) begin
    if (reset_task) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
endmodule

// File: rtl/square_color_ctrl.sv
// Square colour panel controller.
//   clk_khz_1  : 1 kHz clock
//   reset_task : synchronous active-high reset
//   pnl        : panel bundle (buttons in; indices, circle code, busy,
//                press_evt out), all outputs registered
// One press is accepted per IDLE cycle with priority U > C > D; losers
// are dropped. Each accepted press opens a LOCKOUT_CYCLES-long window
// during which every rise is ignored.
module square_color_ctrl
  import square_color_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 200,
  parameter int NUM_COLORS     = 6
) (
  input  logic           clk_khz_1,
  input  logic           reset_task,
  square_color_if.slave  pnl
);
  localparam logic [7:0] LOCK_LD = 8'(LOCKOUT_CYCLES - 1);

  logic [NUM_BTNS-1:0]      btn_raw, rise, grant;
  logic [NUM_BTNS-1:0][2:0] idx;
  state_t                   state, state_nx;
  logic [7:0]               cnt;
  logic [1:0]               circ;
  logic                     evt;

  assign btn_raw = {pnl.btnD, pnl.btnC, pnl.btnU};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_sync_edge u_btn (
      .clk_khz_1  (clk_khz_1),
      .reset_task (reset_task),
      .btn_raw    (btn_raw[i]),
      .rise       (rise[i])
    );
  end

  always_comb begin
    grant    = '0;
    state_nx = state;
    if (state == ST_IDLE) begin
      if (|rise) begin
        state_nx = ST_LOCKOUT;
        if (rise[BTN_U])      grant[BTN_U] = 1'b1;
        else if (rise[BTN_C]) grant[BTN_C] = 1'b1;
        else                  grant[BTN_D] = 1'b1;
      end
    end else if (cnt == 8'd0) begin
      state_nx = ST_IDLE;
    end
  end

  always_ff @(posedge clk_khz_1) begin
    if (reset_task) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
      idx   <= '0;
      circ  <= CIRC_BLACK;
      evt   <= 1'b0;
    end else begin
      state <= state_nx;
      evt   <= |grant;
      if (|grant)
        cnt <= LOCK_LD;
      else if (state == ST_LOCKOUT && cnt != 8'd0)
        cnt <= cnt - 8'd1;
      for (int i = 0; i < NUM_BTNS; i++)
        if (grant[i]) idx[i] <= idx_next(idx[i], NUM_COLORS);
      // Built from the indices as they stood before this edge, so the
      // circle lags an index update by one cycle.
      if (idx[BTN_U] == IDX_RED && idx[BTN_C] == IDX_RED && idx[BTN_D] == IDX_RED)
        circ <= CIRC_RED;
      else if (idx[BTN_U] == IDX_ORANGE && idx[BTN_C] == IDX_ORANGE && idx[BTN_D] == IDX_ORANGE)
        circ <= CIRC_ORANGE;
      else
        circ <= CIRC_BLACK;
    end
  end

  assign pnl.up_idx     = idx[BTN_U];
  assign pnl.ctr_idx    = idx[BTN_C];
  assign pnl.dn_idx     = idx[BTN_D];
  assign pnl.circle_sel = circ;
  assign pnl.busy       = (state == ST_LOCKOUT);
  assign pnl.press_evt  = evt;
endmodule

// File: tb/tb_square_color_ctrl.sv
module tb_square_color_ctrl;
  localparam int L  = 200;
  localparam int NC = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] btns = 3'b000;   // [0]=U [1]=C [2]=D
  int         tests = 0;
  int         fails = 0;
  bit         chk_en = 1'b0;

  square_color_if bus();
  assign bus.btnU = btns[0];
  assign bus.btnC = btns[1];
  assign bus.btnD = btns[2];

  square_color_ctrl #(.LOCKOUT_CYCLES(L), .NUM_COLORS(NC)) dut (
    .clk_khz_1  (clk),
    .reset_task (rst),
    .pnl        (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: a press is seen at an edge when the button was
  // sampled high two edges earlier and low three edges earlier (samples
  // taken under reset count as low). Lockout is a remaining-cycle count.
  int   m_idx [3];
  int   m_lock;
  int   m_circ;
  bit   m_evt;
  bit [2:0] d1, d2, d3;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_idx[i]) m_idx[i] = 0;
      m_lock = 0; m_circ = 0; m_evt = 0;
      d1 = 0; d2 = 0; d3 = 0;
    end else begin
      bit [2:0] r;
      int acc, cn;
      r   = d2 & ~d3;
      acc = -1;
      cn  = (m_idx[0] == 1 && m_idx[1] == 1 && m_idx[2] == 1) ? 1 :
            (m_idx[0] == 4 && m_idx[1] == 4 && m_idx[2] == 4) ? 2 : 0;
      if (m_lock > 0) m_lock--;
      else if (r != 0) begin
        acc = r[0] ? 0 : (r[1] ? 1 : 2);
        m_idx[acc] = (m_idx[acc] + 1) % NC;
        m_lock = L;
      end
      m_evt  = (acc >= 0);
      m_circ = cn;
      d3 = d2; d2 = d1; d1 = btns;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.up_idx",   int'(bus.up_idx),     m_idx[0]);
      chk("m.ctr_idx",  int'(bus.ctr_idx),    m_idx[1]);
      chk("m.dn_idx",   int'(bus.dn_idx),     m_idx[2]);
      chk("m.circle",   int'(bus.circle_sel), m_circ);
      chk("m.busy",     int'(bus.busy),       int'(m_lock > 0));
      chk("m.evt",      int'(bus.press_evt),  int'(m_evt));
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic [2:0] m, input int gap);
    btns = m;
    repeat (3) @(negedge clk);
    btns = 3'b000;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst.up_idx", int'(bus.up_idx), 0);
    chk("rst.busy",   int'(bus.busy),   0);
    chk("rst.circle", int'(bus.circle_sel), 0);

    // U pulse held 3 cycles: update, event and busy at k+2.
    btns = 3'b001;
    repeat (3) @(negedge clk);
    chk("u.up_idx", int'(bus.up_idx), 1);
    chk("u.evt",    int'(bus.press_evt), 1);
    chk("u.busy",   int'(bus.busy), 1);
    btns = 3'b000;
    @(negedge clk);
    chk("u.evt_pulse", int'(bus.press_evt), 0);
    repeat (198) @(negedge clk);
    chk("u.busy_last", int'(bus.busy), 1);
    @(negedge clk);
    chk("u.busy_fall", int'(bus.busy), 0);
    chk("u.circle",    int'(bus.circle_sel), 0);
    repeat (5) @(negedge clk);

    // All three together: only U wins.
    press(3'b111, 0);
    chk("all.up_idx",  int'(bus.up_idx), 2);
    chk("all.ctr_idx", int'(bus.ctr_idx), 0);
    chk("all.dn_idx",  int'(bus.dn_idx), 0);
    repeat (205) @(negedge clk);

    // C, C inside lockout (ignored), C after lockout.
    press(3'b010, 100);
    press(3'b010, 150);
    chk("c.ignored", int'(bus.ctr_idx), 1);
    press(3'b010, 205);
    chk("c.second", int'(bus.ctr_idx), 2);

    // D wraps through six presses.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      press(3'b100, 205);
      chk("d.wrap", int'(bus.dn_idx), (i + 1) % NC);
    end

    // Circle colour: all 1 -> red, all 4 -> orange, then break it.
    do_reset();
    for (int i = 0; i < 3; i++) press(3'b001 << i, 205);
    chk("circ.red", int'(bus.circle_sel), 1);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 3; i++) press(3'b001 << i, 205);
    chk("circ.orange", int'(bus.circle_sel), 2);
    press(3'b001, 205);
    chk("circ.black", int'(bus.circle_sel), 0);
    chk("circ.up5",   int'(bus.up_idx), 5);

    // Reset mid-lockout with D held: press re-fires after release.
    btns = 3'b100;
    repeat (50) @(negedge clk);
    chk("rl.busy_pre", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rl.busy",   int'(bus.busy), 0);
    chk("rl.dn_idx", int'(bus.dn_idx), 0);
    chk("rl.up_idx", int'(bus.up_idx), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rl.dn_early", int'(bus.dn_idx), 0);
    @(negedge clk);
    chk("rl.dn_idx1", int'(bus.dn_idx), 1);
    chk("rl.evt",     int'(bus.press_evt), 1);
    btns = 3'b000;
    repeat (205) @(negedge clk);

    // Random toggling with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 29) == 0) btns[b] = ~btns[b];
      rst = ($urandom_range(0, 799) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    btns = 3'b000;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
